// File: rtl/hpi_mailbox_receiver.sv
// Polls the CY7C67300 HPI STATUS/MAILBOX registers while hpi_irq is high, acknowledges
// each message through the bus engine's req/ack interface and queues words in a FIFO.
module hpi_mailbox_receiver #(
  parameter int          FIFO_AW      = 2,
  parameter int          MBX_FLAG_BIT = 0,
  parameter bit          ACK_ENABLE   = 1'b1,
  parameter logic [15:0] ACK_WORD     = 16'h0FED,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hpi_irq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_reg,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        msg_valid,
  output logic [15:0] msg_data,
  input  logic        msg_ready,
  output logic        busy,
  output logic        timeout_err,
  input  logic        flag_clr
);
  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [1:0] REG_MBX  = 2'b01;
  localparam logic [1:0] REG_STAT = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_STAT, RD_MBX, PUSH, WR_ACK} state_t;

  state_t           state_q, state_d;
  logic             irq_m_q, irq_s_q;
  logic             bus_req_q, bus_req_d, bus_wr_q, bus_wr_d;
  logic [1:0]       bus_reg_q, bus_reg_d;
  logic [15:0]      bus_wdata_q, bus_wdata_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [15:0]      word_q, word_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [DEPTH];
  logic             msg_valid_q, msg_valid_d;
  logic [15:0]      msg_data_q, msg_data_d;
  logic             push, pop, full;
  logic             launch, launch_wr, xfer_done, xfer_tmo;
  logic [1:0]       launch_reg;
  logic [15:0]      launch_wdata;

  assign full = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // Each bus state launches its own request on entry (bus_req low) and waits for ack
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_wr_d      = bus_wr_q;
    bus_reg_d     = bus_reg_q;
    bus_wdata_d   = bus_wdata_q;
    tmo_cnt_d     = tmo_cnt_q;
    word_d        = word_q;
    timeout_err_d = timeout_err_q & ~flag_clr;
    push          = 1'b0;
    launch        = 1'b0;
    launch_wr     = 1'b0;
    launch_reg    = REG_STAT;
    launch_wdata  = bus_wdata_q;
    xfer_done     = bus_req_q & bus_ack;
    xfer_tmo      = bus_req_q & ~bus_ack & (tmo_cnt_q == 8'(TIMEOUT));
    case (state_q)
      IDLE: begin
        if (irq_s_q && !full) begin
          launch  = 1'b1;
          state_d = RD_STAT;
        end
      end
      RD_STAT: begin
        if (xfer_done) state_d = bus_rdata[MBX_FLAG_BIT] ? RD_MBX : IDLE;
      end
      RD_MBX: begin
        launch     = ~bus_req_q;
        launch_reg = REG_MBX;
        if (xfer_done) begin
          word_d  = bus_rdata;
          state_d = PUSH;
        end
      end
      PUSH: begin
        push    = 1'b1;
        state_d = ACK_ENABLE ? WR_ACK : IDLE;
      end
      WR_ACK: begin
        launch       = ~bus_req_q;
        launch_wr    = 1'b1;
        launch_reg   = REG_MBX;
        launch_wdata = ACK_WORD;
        if (xfer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer_done || xfer_tmo) bus_req_d = 1'b0;
    else if (bus_req_q)        tmo_cnt_d = tmo_cnt_q + 8'd1;
    if (xfer_tmo) begin
      state_d       = IDLE;
      timeout_err_d = 1'b1;
    end
    if (launch) begin
      bus_req_d   = 1'b1;
      bus_wr_d    = launch_wr;
      bus_reg_d   = launch_reg;
      bus_wdata_d = launch_wdata;
      tmo_cnt_d   = 8'd0;
    end
  end

  // Head register is refreshed from the post-update pointers; a word written to the
  // slot that becomes the head this cycle is forwarded directly.
  always_comb begin
    pop      = msg_valid_q & msg_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    msg_valid_d = (wr_ptr_d != rd_ptr_d);
    msg_data_d  = msg_data_q;
    if (push && (rd_ptr_d == wr_ptr_q)) msg_data_d = word_q;
    else if (msg_valid_d)               msg_data_d = mem_q[rd_ptr_d[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      irq_m_q       <= 1'b0;
      irq_s_q       <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_reg_q     <= REG_STAT;
      bus_wdata_q   <= 16'h0000;
      tmo_cnt_q     <= 8'd0;
      timeout_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      msg_valid_q   <= 1'b0;
      msg_data_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      irq_m_q       <= hpi_irq;
      irq_s_q       <= irq_m_q;
      bus_req_q     <= bus_req_d;
      bus_wr_q      <= bus_wr_d;
      bus_reg_q     <= bus_reg_d;
      bus_wdata_q   <= bus_wdata_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      msg_valid_q   <= msg_valid_d;
      msg_data_q    <= msg_data_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= word_q;
  end

  assign bus_req     = bus_req_q;
  assign bus_wr      = bus_wr_q;
  assign bus_reg     = bus_reg_q;
  assign bus_wdata   = bus_wdata_q;
  assign msg_valid   = msg_valid_q;
  assign msg_data    = msg_data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_hpi_mailbox_receiver.sv
// Bench for hpi_mailbox_receiver: a CY7C67300-like register responder plus a queue
// model of the delivered message stream and of the STATUS/MAILBOX/ACK transaction order.
`timescale 1ns/1ps
module tb_hpi_mailbox_receiver;
  localparam int          TIMEOUT  = 255;
  localparam logic [15:0] ACK_WORD = 16'h0FED;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0, reset = 1'b1, hpi_irq = 1'b0, bus_ack = 1'b0;
  logic        msg_ready = 1'b0, flag_clr = 1'b0;
  logic [15:0] bus_rdata = 16'h0000;
  logic        bus_req, bus_wr, msg_valid, busy, timeout_err;
  logic [1:0]  bus_reg;
  logic [15:0] bus_wdata, msg_data;

  hpi_mailbox_receiver dut (
    .clk(clk), .reset(reset), .hpi_irq(hpi_irq),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_reg(bus_reg), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .busy(busy), .timeout_err(timeout_err), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Chip side: messages waiting in the CY mailbox; a MAILBOX read consumes one.
  logic [15:0] pending[$];
  bit irq_force = 0, ack_hold = 0, spurious_en = 0;
  int ack_wait = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (reset) begin
        pending.delete();
        ack_wait = 0;
      end else if (bus_req && !ack_hold) begin
        if (ack_wait == 0) begin
          bus_ack = 1'b1;
          if (bus_wr)                bus_rdata = 16'($urandom);
          else if (bus_reg == 2'b11) bus_rdata = {15'($urandom), pending.size() != 0};
          else if (bus_reg == 2'b01) bus_rdata = (pending.size() != 0) ? pending.pop_front() : 16'hDEAD;
          else                       bus_rdata = 16'($urandom);
          ack_wait = $urandom_range(0, 3);
        end else begin
          ack_wait--;
        end
      end else if (!bus_req && spurious_en && $urandom_range(0, 7) == 0) begin
        bus_ack   = 1'b1;
        bus_rdata = 16'($urandom);
      end
      hpi_irq = irq_force || (pending.size() != 0);
    end
  end

  // Reference model, evaluated once per cycle at the falling edge
  logic [15:0] expq[$];
  int          txn_log[$];
  bit          stage_v, exp_err, tmo_now, exp_req_low, prev_req, hold_chk;
  logic [15:0] stage_d, rise_wdata, last_wdata;
  logic [1:0]  rise_reg;
  logic        rise_wr;
  int          next_kind, run_len, prev_size, n_popped;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      stage_v = 0; exp_err = 0; exp_req_low = 0; prev_req = 0; hold_chk = 0;
      next_kind = 0; run_len = 0; prev_size = 0;
    end else begin
      check("msg_valid", msg_valid, expq.size() != 0);
      if (expq.size() != 0) check("msg_data", msg_data, expq[0]);
      check("timeout_err", timeout_err, exp_err);
      if (exp_req_low) check("req_drop_on_timeout", bus_req, 0);
      if (bus_req) check("busy_with_req", busy, 1);
      if (bus_req && !prev_req) begin
        check("txn_wr", bus_wr, next_kind == 2);
        check("txn_reg", bus_reg, (next_kind == 0) ? 2'b11 : 2'b01);
        if (next_kind == 2) check("txn_wdata", bus_wdata, ACK_WORD);
        if (next_kind == 0) check("poll_only_with_room", prev_size < DEPTH, 1);
        rise_wr = bus_wr; rise_reg = bus_reg; rise_wdata = bus_wdata;
        run_len = 0; hold_chk = 1;
      end else if (hold_chk) begin
        check("hold_wr", bus_wr, rise_wr);
        check("hold_reg", bus_reg, rise_reg);
        check("hold_wdata", bus_wdata, rise_wdata);
        if (!bus_req) hold_chk = 0;
      end
      prev_size = expq.size();
      if (expq.size() != 0 && msg_ready) begin
        void'(expq.pop_front());
        n_popped++;
      end
      if (stage_v) begin
        expq.push_back(stage_d);
        stage_v = 0;
      end
      tmo_now = 0;
      if (bus_req && bus_ack) begin
        txn_log.push_back(int'({bus_wr, bus_reg}));
        if (bus_wr) last_wdata = bus_wdata;
        case (next_kind)
          0:       next_kind = bus_rdata[0] ? 1 : 0;
          1:       begin stage_v = 1; stage_d = bus_rdata; next_kind = 2; end
          default: next_kind = 0;
        endcase
      end else if (bus_req) begin
        if (run_len == TIMEOUT) begin
          tmo_now = 1;
          next_kind = 0;
        end else begin
          run_len++;
        end
      end
      exp_req_low = tmo_now;
      if (flag_clr) exp_err = 0;
      if (tmo_now)  exp_err = 1;
      prev_req = bus_req;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic pop_one(output logic [15:0] d, output bit ok);
    ok = 0; d = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (msg_valid) begin ok = 1; break; end
    end
    if (ok) begin
      @(posedge clk); #2; msg_ready = 1'b1;
      @(negedge clk); d = msg_data;
      @(posedge clk); #2; msg_ready = 1'b0;
    end
  endtask

  task automatic wait_quiet(input int max_cyc, output bit ok);
    int calm;
    calm = 0; ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && !bus_req && pending.size() == 0 && !hpi_irq) calm++;
      else calm = 0;
      if (calm >= 4) begin ok = 1; break; end
    end
  endtask

  function automatic int log_code();
    int c;
    c = 0;
    foreach (txn_log[i]) c = c * 10 + txn_log[i];
    return c;
  endfunction

  initial begin
    bit ok, found;
    logic [15:0] d;
    int cnt, nst, nmb, n_posted;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_reg", bus_reg, 2'b11);
    check("rst_bus_wdata", bus_wdata, 16'h0000);
    check("rst_msg_valid", msg_valid, 0);
    check("rst_msg_data", msg_data, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #2; reset = 1'b0;

    // One message: STATUS read, MAILBOX read, acknowledge write
    txn_log.delete();
    @(posedge clk); #2; pending.push_back(16'hCAFE);
    wait_quiet(300, ok);
    check("t1_done", ok, 1);
    check("t1_sequence", log_code(), 315);
    check("t1_ack_wdata", last_wdata, 16'h0FED);
    check("t1_msg_valid", msg_valid, 1);
    check("t1_msg_data", msg_data, 16'hCAFE);
    check("t1_busy", busy, 0);
    pop_one(d, ok);
    check("t1_pop", d, 16'hCAFE);

    // Interrupt with no pending flag: repeated STATUS polls only
    txn_log.delete();
    @(posedge clk); #2; irq_force = 1;
    repeat (40) @(negedge clk);
    @(posedge clk); #2; irq_force = 0;
    wait_quiet(100, ok);
    nst = 0; nmb = 0;
    foreach (txn_log[i]) begin
      if (txn_log[i] == 3) nst++;
      if (txn_log[i] == 1) nmb++;
    end
    check("t2_quiet", ok, 1);
    check("t2_repoll", nst >= 2, 1);
    check("t2_no_mbx_read", nmb, 0);
    check("t2_no_msg", msg_valid, 0);

    // Five messages into a four-entry FIFO with the consumer stalled
    @(posedge clk); #2;
    for (int i = 1; i <= 5; i++) pending.push_back(16'(16'h1111 * i));
    repeat (250) @(negedge clk);
    check("t3_left_in_mailbox", pending.size(), 1);
    check("t3_head", msg_data, 16'h1111);
    check("t3_valid", msg_valid, 1);
    check("t3_idle", busy, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || bus_req) cnt++;
    end
    check("t3_no_fifth_read", cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      pop_one(d, ok);
      check("t3_pop_ok", ok, 1);
      check("t3_pop_order", d, 16'(16'h1111 * i));
    end
    wait_quiet(200, ok);
    check("t3_quiet", ok, 1);

    // Withheld acknowledge: abort and sticky error, then clear
    @(posedge clk); #2; ack_hold = 1; irq_force = 1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req) begin found = 1; break; end
    end
    check("t4_req_seen", found, 1);
    cnt = 0;
    while (bus_req && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    ack_hold = 0; irq_force = 0;
    check("t4_req_high_cycles", cnt, TIMEOUT + 1);
    check("t4_req_dropped", bus_req, 0);
    check("t4_err_set", timeout_err, 1);
    wait_quiet(100, ok);
    check("t4_err_sticky", timeout_err, 1);
    @(posedge clk); #2; flag_clr = 1'b1;
    @(posedge clk); #2; flag_clr = 1'b0;
    @(negedge clk);
    check("t4_err_cleared", timeout_err, 0);

    // Reset while a MAILBOX read is outstanding, with a word already queued
    @(posedge clk); #2; pending.push_back(16'hAAAA);
    wait_quiet(200, ok);
    check("t5_first_queued", msg_valid, 1);
    @(posedge clk); #2; pending.push_back(16'hBBBB);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_req && !bus_wr && bus_reg == 2'b01) begin found = 1; break; end
    end
    check("t5_mbx_read_seen", found, 1);
    #1; reset = 1'b1; #1;
    check("t5_bus_req", bus_req, 0);
    check("t5_bus_wr", bus_wr, 0);
    check("t5_bus_reg", bus_reg, 2'b11);
    check("t5_bus_wdata", bus_wdata, 16'h0000);
    check("t5_msg_valid", msg_valid, 0);
    check("t5_msg_data", msg_data, 16'h0000);
    check("t5_busy", busy, 0);
    check("t5_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;

    // Randomized traffic: full-throughput drain, random back-pressure, burst stalls
    n_posted = 0; n_popped = 0;
    spurious_en = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (c < 1200)      msg_ready = 1'b1;
      else if (c < 2400) msg_ready = 1'($urandom_range(0, 1));
      else               msg_ready = ((c / 80) % 2) == 0;
      if (pending.size() < 2 && $urandom_range(0, 3) == 0) begin
        pending.push_back(16'($urandom));
        n_posted++;
      end
      irq_force = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #2;
    spurious_en = 0; irq_force = 0; msg_ready = 1'b1;
    wait_quiet(1500, ok);
    repeat (4) @(negedge clk);
    check("rand_drained", ok, 1);
    check("rand_all_delivered", n_popped, n_posted);
    check("rand_fifo_empty", msg_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
